// File: rtl/arith_share_ctrl_if.sv
// Request, shared-unit and result signals of the two-requester arithmetic controller.
// The controller sits on the slave side; requesters, shared unit and consumer use the master side.
interface arith_share_ctrl_if;
   logic       iReqA;
   logic [1:0] iOpA;
   logic [3:0] iAA;
   logic [3:0] iBA;
   logic       oGntA;
   logic       iReqB;
   logic [1:0] iOpB;
   logic [3:0] iAB;
   logic [3:0] iBB;
   logic       oGntB;
   logic [3:0] oNum1;
   logic [3:0] oNum2;
   logic [4:0] iSum;
   logic [3:0] iSub;
   logic [3:0] iDiv;
   logic [7:0] iMult;
   logic [7:0] oResult;
   logic       oDivZero;
   logic       oValid;
   logic       oOwner;
   logic       iAck;
   logic       oBusy;

   modport slave (
      input  iReqA, iOpA, iAA, iBA, iReqB, iOpB, iAB, iBB,
      input  iSum, iSub, iDiv, iMult, iAck,
      output oGntA, oGntB, oNum1, oNum2, oResult, oDivZero, oValid, oOwner, oBusy
   );

   modport master (
      output iReqA, iOpA, iAA, iBA, iReqB, iOpB, iAB, iBB,
      output iSum, iSub, iDiv, iMult, iAck,
      input  oGntA, oGntB, oNum1, oNum2, oResult, oDivZero, oValid, oOwner, oBusy
   );
endinterface

// File: rtl/arith_share_ctrl.sv
// Round-robin controller sharing one combinational 4-bit arithmetic unit between requesters A and B.
// Operands are held for SETTLE cycles, then the selected result is returned with a valid/ack handshake.
module arith_share_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input logic               iClk,
   input logic               iRst_n,
   arith_share_ctrl_if.slave bus
);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg;
   logic [1:0] op_reg;
   logic [3:0] num1_reg, num2_reg;
   logic [7:0] result_reg;
   logic       divzero_reg, valid_reg, owner_reg, prefer_b_reg;
   logic       gnt_a, gnt_b, capture;
   logic [7:0] result_next;
   logic       divzero_next;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state_reg <= ST_IDLE;
      else         state_reg <= state_next;
   end

   // Grant is combinational so the requester sees it in the cycle its request is accepted.
   always_comb begin
      state_next = state_reg;
      gnt_a      = 1'b0;
      gnt_b      = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (iRst_n) begin
               if (bus.iReqA && (!bus.iReqB || !prefer_b_reg)) gnt_a = 1'b1;
               else if (bus.iReqB)                            gnt_b = 1'b1;
               if (gnt_a || gnt_b) state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_reg == 4'd1) begin
               capture    = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.iAck) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      result_next  = 8'h00;
      divzero_next = 1'b0;
      case (op_reg)
         2'b00: result_next = {3'b000, bus.iSum};
         2'b01: result_next = {4'h0, bus.iSub};
         2'b10: begin
            if (num2_reg == 4'd0) divzero_next = 1'b1;
            else                  result_next  = {4'h0, bus.iDiv};
         end
         default: result_next = bus.iMult;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_reg      <= 4'd0;
         op_reg       <= 2'b00;
         num1_reg     <= 4'd0;
         num2_reg     <= 4'd0;
         result_reg   <= 8'h00;
         divzero_reg  <= 1'b0;
         valid_reg    <= 1'b0;
         owner_reg    <= 1'b0;
         prefer_b_reg <= 1'b0;
      end else begin
         if (gnt_a) begin
            op_reg       <= bus.iOpA;
            num1_reg     <= bus.iAA;
            num2_reg     <= bus.iBA;
            owner_reg    <= 1'b0;
            cnt_reg      <= SETTLE_LOAD;
            prefer_b_reg <= 1'b1;
         end else if (gnt_b) begin
            op_reg       <= bus.iOpB;
            num1_reg     <= bus.iAB;
            num2_reg     <= bus.iBB;
            owner_reg    <= 1'b1;
            cnt_reg      <= SETTLE_LOAD;
            prefer_b_reg <= 1'b0;
         end else if (state_reg == ST_SETTLE) begin
            cnt_reg <= cnt_reg - 4'd1;
         end

         if (capture) begin
            result_reg  <= result_next;
            divzero_reg <= divzero_next;
            valid_reg   <= 1'b1;
         end else if (state_reg == ST_DONE && bus.iAck) begin
            valid_reg   <= 1'b0;
            divzero_reg <= 1'b0;
         end
      end
   end

   assign bus.oGntA    = gnt_a;
   assign bus.oGntB    = gnt_b;
   assign bus.oNum1    = num1_reg;
   assign bus.oNum2    = num2_reg;
   assign bus.oResult  = result_reg;
   assign bus.oDivZero = divzero_reg;
   assign bus.oValid   = valid_reg;
   assign bus.oOwner   = owner_reg;
   assign bus.oBusy    = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_arith_share_ctrl.sv
// Bench for arith_share_ctrl: one instance with SETTLE=1 and one with SETTLE=3 share the stimulus;
// expected results go into a scoreboard at grant time and are compared when oValid appears.
module tb_arith_share_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0, ack = 1'b0;
   logic [1:0] op_a = 2'b00, op_b = 2'b00;
   logic [3:0] aa = 4'd0, ba = 4'd0, ab = 4'd0, bb = 4'd0;

   arith_share_ctrl_if bus1 ();
   arith_share_ctrl_if bus3 ();

   assign bus1.iReqA = req_a;  assign bus1.iOpA = op_a;  assign bus1.iAA = aa;  assign bus1.iBA = ba;
   assign bus1.iReqB = req_b;  assign bus1.iOpB = op_b;  assign bus1.iAB = ab;  assign bus1.iBB = bb;
   assign bus1.iAck  = ack;
   assign bus1.iSum  = {1'b0, bus1.oNum1} + {1'b0, bus1.oNum2};
   assign bus1.iSub  = bus1.oNum1 - bus1.oNum2;
   assign bus1.iDiv  = (bus1.oNum2 == 4'd0) ? 4'hF : bus1.oNum1 / bus1.oNum2;
   assign bus1.iMult = {4'h0, bus1.oNum1} * {4'h0, bus1.oNum2};

   assign bus3.iReqA = req_a;  assign bus3.iOpA = op_a;  assign bus3.iAA = aa;  assign bus3.iBA = ba;
   assign bus3.iReqB = req_b;  assign bus3.iOpB = op_b;  assign bus3.iAB = ab;  assign bus3.iBB = bb;
   assign bus3.iAck  = ack;
   assign bus3.iSum  = {1'b0, bus3.oNum1} + {1'b0, bus3.oNum2};
   assign bus3.iSub  = bus3.oNum1 - bus3.oNum2;
   assign bus3.iDiv  = (bus3.oNum2 == 4'd0) ? 4'hF : bus3.oNum1 / bus3.oNum2;
   assign bus3.iMult = {4'h0, bus3.oNum1} * {4'h0, bus3.oNum2};

   arith_share_ctrl #(.SETTLE(1)) u_dut1 (.iClk(clk), .iRst_n(rst_n), .bus(bus1.slave));
   arith_share_ctrl #(.SETTLE(3)) u_dut3 (.iClk(clk), .iRst_n(rst_n), .bus(bus3.slave));

   logic       sel3 = 1'b0;
   int         settle_cur = 1;
   logic       o_gnt_a, o_gnt_b, o_valid, o_divzero, o_owner, o_busy;
   logic [3:0] o_num1, o_num2;
   logic [7:0] o_result;

   always_comb begin
      if (sel3) begin
         o_gnt_a = bus3.oGntA;  o_gnt_b = bus3.oGntB;  o_valid = bus3.oValid;  o_divzero = bus3.oDivZero;
         o_owner = bus3.oOwner; o_busy  = bus3.oBusy;  o_num1  = bus3.oNum1;   o_num2    = bus3.oNum2;
         o_result = bus3.oResult;
      end else begin
         o_gnt_a = bus1.oGntA;  o_gnt_b = bus1.oGntB;  o_valid = bus1.oValid;  o_divzero = bus1.oDivZero;
         o_owner = bus1.oOwner; o_busy  = bus1.oBusy;  o_num1  = bus1.oNum1;   o_num2    = bus1.oNum2;
         o_result = bus1.oResult;
      end
   end

   typedef struct packed {
      logic [7:0] result;
      logic       divzero;
      logic       owner;
   } exp_t;

   typedef struct {
      logic       is_b;
      logic [1:0] op;
      logic [3:0] x;
      logic [3:0] y;
      exp_t       exp;
   } vec_t;

   vec_t vecs [8];
   exp_t sb [$];
   int   checks = 0, errors = 0, cyc = 0, gnt_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic set_vec(input int i, input logic is_b, input logic [1:0] op, input logic [3:0] x,
                          input logic [3:0] y, input logic [7:0] res, input logic dz);
      vecs[i].is_b = is_b;
      vecs[i].op   = op;
      vecs[i].x    = x;
      vecs[i].y    = y;
      vecs[i].exp  = '{result: res, divzero: dz, owner: is_b};
   endtask

   task automatic drive_req(input logic is_b, input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
      if (is_b) begin req_b = 1'b1; op_b = op; ab = x; bb = y; end
      else      begin req_a = 1'b1; op_a = op; aa = x; ba = y; end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic await_grant(input logic is_b, input exp_t e, input string name);
      logic       got = 1'b0;
      logic [3:0] x, y;
      for (int i = 0; i < 40; i++) begin
         if ((is_b ? o_gnt_b : o_gnt_a) === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({name, "_grant"}, 32'(got), 32'(1));
      if (got) begin
         chk({name, "_other_gnt"}, 32'(is_b ? o_gnt_a : o_gnt_b), 32'(0));
         gnt_cyc = cyc;
         x = is_b ? ab : aa;
         y = is_b ? bb : ba;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (is_b) req_b = 1'b0;
         else      req_a = 1'b0;
         @(negedge clk);
         chk({name, "_num1"}, 32'(o_num1), 32'(x));
         chk({name, "_num2"}, 32'(o_num2), 32'(y));
         chk({name, "_busy"}, 32'(o_busy), 32'(1));
         chk({name, "_gnt_pulse"}, 32'(is_b ? o_gnt_b : o_gnt_a), 32'(0));
      end
   endtask

   task automatic await_result(input string name, input logic do_ack);
      logic got = 1'b0;
      exp_t e   = '0;
      for (int i = 0; i < 40; i++) begin
         if (o_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({name, "_valid"}, 32'(got), 32'(1));
      if (got) begin
         chk({name, "_latency"}, 32'(cyc - gnt_cyc), 32'(settle_cur + 1));
         chk({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({name, "_result"}, 32'(o_result), 32'(e.result));
            chk({name, "_divzero"}, 32'(o_divzero), 32'(e.divzero));
            chk({name, "_owner"}, 32'(o_owner), 32'(e.owner));
            $display("txn %s: owner=%0d result=0x%02h divzero=%0d latency=%0d",
                     name, o_owner, o_result, o_divzero, cyc - gnt_cyc);
         end
         if (do_ack) begin
            @(posedge clk);
            #1 ack = 1'b1;
            @(posedge clk);
            #1 ack = 1'b0;
            @(negedge clk);
            chk({name, "_ack_valid"}, 32'(o_valid), 32'(0));
            chk({name, "_ack_divzero"}, 32'(o_divzero), 32'(0));
            chk({name, "_ack_busy"}, 32'(o_busy), 32'(0));
            chk({name, "_held_result"}, 32'(o_result), 32'(e.result));
            chk({name, "_held_owner"}, 32'(o_owner), 32'(e.owner));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int a_gnt, ack_cyc, rel_cyc;

      set_vec(0, 1'b0, 2'b00, 4'd9,  4'd8,  8'h11, 1'b0);
      set_vec(1, 1'b1, 2'b10, 4'd7,  4'd0,  8'h00, 1'b1);
      set_vec(2, 1'b1, 2'b10, 4'd13, 4'd4,  8'h03, 1'b0);
      set_vec(3, 1'b0, 2'b11, 4'd12, 4'd11, 8'h84, 1'b0);
      set_vec(4, 1'b0, 2'b01, 4'd0,  4'd1,  8'h0F, 1'b0);
      set_vec(5, 1'b1, 2'b00, 4'd15, 4'd15, 8'h1E, 1'b0);
      set_vec(6, 1'b0, 2'b10, 4'd15, 4'd1,  8'h0F, 1'b0);
      set_vec(7, 1'b1, 2'b11, 4'd0,  4'd9,  8'h00, 1'b0);

      // Reset state of the SETTLE=1 instance
      repeat (2) @(negedge clk);
      chk("rst_gnt_a", 32'(o_gnt_a), 32'(0));
      chk("rst_gnt_b", 32'(o_gnt_b), 32'(0));
      chk("rst_num1", 32'(o_num1), 32'(0));
      chk("rst_num2", 32'(o_num2), 32'(0));
      chk("rst_result", 32'(o_result), 32'(0));
      chk("rst_divzero", 32'(o_divzero), 32'(0));
      chk("rst_valid", 32'(o_valid), 32'(0));
      chk("rst_owner", 32'(o_owner), 32'(0));
      chk("rst_busy", 32'(o_busy), 32'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         drive_req(vecs[i].is_b, vecs[i].op, vecs[i].x, vecs[i].y);
         await_grant(vecs[i].is_b, vecs[i].exp, $sformatf("vec%0d", i));
         await_result($sformatf("vec%0d", i), 1'b1);
      end

      // Contested requests right after reset: A first, then B, then A again
      apply_reset();
      drive_req(1'b0, 2'b01, 4'd3, 4'd5);
      drive_req(1'b1, 2'b11, 4'd15, 4'd15);
      await_grant(1'b0, '{result: 8'h0E, divzero: 1'b0, owner: 1'b0}, "contest1_a");
      await_result("contest1_a", 1'b1);
      await_grant(1'b1, '{result: 8'hE1, divzero: 1'b0, owner: 1'b1}, "contest1_b");
      await_result("contest1_b", 1'b1);
      @(posedge clk);
      #1;
      drive_req(1'b0, 2'b01, 4'd3, 4'd5);
      drive_req(1'b1, 2'b11, 4'd15, 4'd15);
      await_grant(1'b0, '{result: 8'h0E, divzero: 1'b0, owner: 1'b0}, "contest2_a");
      req_b = 1'b0;
      await_result("contest2_a", 1'b1);

      // Ack held high: accepted on the first DONE cycle, next grant SETTLE+2 cycles later
      @(posedge clk);
      #1 ack = 1'b1;
      drive_req(1'b0, 2'b00, 4'd9, 4'd8);
      await_grant(1'b0, '{result: 8'h11, divzero: 1'b0, owner: 1'b0}, "tput_a");
      a_gnt = gnt_cyc;
      @(posedge clk);
      #1;
      drive_req(1'b1, 2'b01, 4'd5, 4'd3);
      await_result("tput_a", 1'b0);
      await_grant(1'b1, '{result: 8'h02, divzero: 1'b0, owner: 1'b1}, "tput_b");
      chk("tput_spacing", 32'(gnt_cyc - a_gnt), 32'(settle_cur + 2));
      ack = 1'b0;
      await_result("tput_b", 1'b1);

      // SETTLE=3 instance
      sel3 = 1'b1;
      settle_cur = 3;
      apply_reset();
      drive_req(1'b0, 2'b11, 4'd13, 4'd7);
      await_grant(1'b0, '{result: 8'h5B, divzero: 1'b0, owner: 1'b0}, "s3_mult");
      @(posedge clk);
      #1;
      drive_req(1'b0, 2'b01, 4'd2, 4'd9);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("s3_settle_num1", 32'(o_num1), 32'(13));
         chk("s3_settle_num2", 32'(o_num2), 32'(7));
         chk("s3_settle_gnt", 32'(o_gnt_a), 32'(0));
         chk("s3_settle_valid", 32'(o_valid), 32'(0));
      end
      await_result("s3_mult", 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("s3_hold_valid", 32'(o_valid), 32'(1));
         chk("s3_hold_result", 32'(o_result), 32'(8'h5B));
         chk("s3_hold_gnt", 32'(o_gnt_a), 32'(0));
      end
      @(posedge clk);
      #1 ack = 1'b1;
      ack_cyc = cyc;
      @(negedge clk);
      chk("s3_no_early_gnt", 32'(o_gnt_a), 32'(0));
      @(posedge clk);
      #1 ack = 1'b0;
      await_grant(1'b0, '{result: 8'h09, divzero: 1'b0, owner: 1'b0}, "s3_sub");
      chk("s3_gnt_after_ack", 32'(gnt_cyc - ack_cyc), 32'(1));
      await_result("s3_sub", 1'b1);

      // Reset during SETTLE aborts the operation; pending B is granted once reset is released
      @(posedge clk);
      #1;
      drive_req(1'b0, 2'b00, 4'd5, 4'd6);
      await_grant(1'b0, '{result: 8'h0B, divzero: 1'b0, owner: 1'b0}, "abort_a");
      @(posedge clk);
      #1;
      drive_req(1'b1, 2'b10, 4'd9, 4'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(o_valid), 32'(0));
      chk("abort_result", 32'(o_result), 32'(0));
      chk("abort_num1", 32'(o_num1), 32'(0));
      chk("abort_num2", 32'(o_num2), 32'(0));
      chk("abort_busy", 32'(o_busy), 32'(0));
      chk("abort_gnt_b", 32'(o_gnt_b), 32'(0));
      chk("abort_divzero", 32'(o_divzero), 32'(0));
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_hold_valid", 32'(o_valid), 32'(0));
         chk("abort_hold_gnt_b", 32'(o_gnt_b), 32'(0));
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      rel_cyc = cyc;
      await_grant(1'b1, '{result: 8'h04, divzero: 1'b0, owner: 1'b1}, "abort_b");
      chk("abort_b_first_idle", 32'(gnt_cyc - rel_cyc), 32'(0));
      await_result("abort_b", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
